// File: rtl/diffeq_job_sequencer_pkg.sv
// rtl/diffeq_job_sequencer_pkg.sv - shared widths and FSM encoding for the diffeq job sequencer
package diffeq_job_sequencer_pkg;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_JOB_ADDR_WIDTH = 4;
  localparam int DEF_STEP_WIDTH     = 16;
  localparam int DEF_MAX_STEPS      = 1000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CLEAR = 3'd2,
    S_RUN   = 3'd3,
    S_EMIT  = 3'd4,
    S_FIN   = 3'd5
  } seq_state_e;

endpackage

// File: rtl/diffeq_job_table.sv
// rtl/diffeq_job_table.sv - job table: synchronous write, combinational read, {a, dx} per entry
module diffeq_job_table #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   waddr_i,
  input  logic [2*DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0]   raddr_i,
  output logic [2*DATA_WIDTH-1:0] rdata_o
);

  // No reset: job contents must survive a sequencer reset.
  logic [2*DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/diffeq_job_sequencer.sv
// rtl/diffeq_job_sequencer.sv - runs a table of (a, dx) jobs through the diffeq solver and returns results
module diffeq_job_sequencer
  import diffeq_job_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int JOB_ADDR_WIDTH = DEF_JOB_ADDR_WIDTH,
  parameter int STEP_WIDTH     = DEF_STEP_WIDTH,
  parameter int MAX_STEPS      = DEF_MAX_STEPS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      job_we,
  input  logic [JOB_ADDR_WIDTH-1:0] job_addr,
  input  logic [DATA_WIDTH-1:0]     job_a,
  input  logic [DATA_WIDTH-1:0]     job_dx,
  input  logic [JOB_ADDR_WIDTH:0]   num_jobs,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      solver_reset,
  output logic [DATA_WIDTH-1:0]     aport,
  output logic [DATA_WIDTH-1:0]     dxport,
  input  logic [DATA_WIDTH-1:0]     xport,
  input  logic [DATA_WIDTH-1:0]     yport,
  input  logic [DATA_WIDTH-1:0]     uport,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [JOB_ADDR_WIDTH-1:0] res_idx,
  output logic [DATA_WIDTH-1:0]     res_y,
  output logic [DATA_WIDTH-1:0]     res_u,
  output logic [STEP_WIDTH-1:0]     res_steps,
  output logic                      res_timeout
);

  localparam logic [JOB_ADDR_WIDTH:0] NUM_ENTRIES = {1'b1, {JOB_ADDR_WIDTH{1'b0}}};
  localparam logic [STEP_WIDTH-1:0]   LAST_STEP   = STEP_WIDTH'(MAX_STEPS - 1);

  seq_state_e                state_q, state_d;
  logic [JOB_ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [JOB_ADDR_WIDTH-1:0] last_q, last_d;
  logic [STEP_WIDTH-1:0]     steps_q, steps_d;
  logic [DATA_WIDTH-1:0]     a_q, a_d;
  logic [DATA_WIDTH-1:0]     dx_q, dx_d;
  logic [DATA_WIDTH-1:0]     y_q, y_d;
  logic [DATA_WIDTH-1:0]     u_q, u_d;
  logic                      timeout_q, timeout_d;

  logic                      tbl_we;
  logic [2*DATA_WIDTH-1:0]   tbl_rdata;

  assign tbl_we = job_we && (state_q == S_IDLE);

  diffeq_job_table #(
    .ADDR_WIDTH (JOB_ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_table (
    .clk     (clk),
    .we_i    (tbl_we),
    .waddr_i (job_addr),
    .wdata_i ({job_a, job_dx}),
    .raddr_i (idx_q),
    .rdata_o (tbl_rdata)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    steps_d   = steps_q;
    a_d       = a_q;
    dx_d      = dx_q;
    y_d       = y_q;
    u_d       = u_q;
    timeout_d = timeout_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_jobs == '0) begin
            state_d = S_FIN;
          end else begin
            // A count of exactly 2**W wraps to all-ones below, matching the clamp.
            last_d  = (num_jobs > NUM_ENTRIES) ? '1
                                               : num_jobs[JOB_ADDR_WIDTH-1:0] - 1'b1;
            idx_d   = '0;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        a_d     = tbl_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
        dx_d    = tbl_rdata[DATA_WIDTH-1:0];
        state_d = S_CLEAR;
      end
      S_CLEAR: begin
        steps_d = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (xport >= a_q) begin
          y_d       = yport;
          u_d       = uport;
          timeout_d = 1'b0;
          state_d   = S_EMIT;
        end else if (steps_q == LAST_STEP) begin
          steps_d   = steps_q + 1'b1;
          y_d       = yport;
          u_d       = uport;
          timeout_d = 1'b1;
          state_d   = S_EMIT;
        end else begin
          steps_d = steps_q + 1'b1;
        end
      end
      S_EMIT: begin
        if (res_ready) begin
          if (idx_q == last_q) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      last_q    <= '0;
      steps_q   <= '0;
      a_q       <= '0;
      dx_q      <= '0;
      y_q       <= '0;
      u_q       <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      steps_q   <= steps_d;
      a_q       <= a_d;
      dx_q      <= dx_d;
      y_q       <= y_d;
      u_q       <= u_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_FIN);
  assign solver_reset = reset || (state_q == S_CLEAR);
  assign res_valid    = (state_q == S_EMIT);
  assign aport        = a_q;
  assign dxport       = dx_q;
  assign res_idx      = idx_q;
  assign res_y        = y_q;
  assign res_u        = u_q;
  assign res_steps    = steps_q;
  assign res_timeout  = timeout_q;

endmodule
